// File: rtl/mac_pkg.sv
// Shared types and operand widths for the MAC operand sequencer and its accumulator.
package mac_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
endpackage

// File: rtl/mac_accumulator.sv
// Wide accumulator with carry capture: adds a zero-extended product per enable and keeps a sticky overflow flag.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum_d;

    // One extra bit on the adder so the carry out of the accumulator can be captured.
    assign sum_d = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            acc_q <= sum_d[ACC_W-1:0];
            ovf_q <= ovf_q | sum_d[ACC_W];
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;
endmodule

// File: rtl/mac_operand_sequencer.sv
// Burst sequencer around an external 4x4 array multiplier: loads operand pairs, accumulates products, hands off the sum.
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_m,
    input  logic [OP_W-1:0]   in_q,
    output logic [OP_W-1:0]   mul_m,
    output logic [OP_W-1:0]   mul_q,
    input  logic [PROD_W-1:0] mul_p,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    output logic              busy
);
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OP_W-1:0]  mul_m_q;
    logic [OP_W-1:0]  mul_q_q;
    logic             acc_clr;
    logic             acc_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_m_q <= '0;
            mul_q_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= len;
                        state_q <= (len == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        mul_m_q <= in_m;
                        mul_q_q <= in_q;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    cnt_q   <= cnt_q - CNT_W'(1);
                    state_q <= (cnt_q == CNT_W'(1)) ? DONE : LOAD;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The product of the pair loaded in LOAD is settled on mul_p throughout MAC.
    assign acc_clr = (state_q == IDLE) && start;
    assign acc_en  = (state_q == MAC);

    mac_accumulator #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .prod (mul_p),
        .acc  (acc_out),
        .ovf  (ovf)
    );

    assign mul_m     = mul_m_q;
    assign mul_q     = mul_q_q;
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer: default instance plus a narrow-accumulator instance for overflow.
module tb_mac_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_m;
    logic [3:0] in_q;
    logic [3:0] mul_m;
    logic [3:0] mul_q;
    logic [7:0] mul_p;
    logic [11:0] acc_out;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic       busy;

    logic       start2;
    logic [3:0] len2;
    logic       in_valid2;
    logic       in_ready2;
    logic [3:0] in_m2;
    logic [3:0] in_q2;
    logic [3:0] mul_m2;
    logic [3:0] mul_q2;
    logic [7:0] mul_p2;
    logic [7:0] acc_out2;
    logic       out_valid2;
    logic       out_ready2;
    logic       ovf2;
    logic       busy2;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_acc = 0;

    always #5 clk = ~clk;

    // Behavioural stand-ins for the external array multipliers.
    assign mul_p  = {4'b0, mul_m} * {4'b0, mul_q};
    assign mul_p2 = {4'b0, mul_m2} * {4'b0, mul_q2};

    mac_operand_sequencer #(.ACC_W(12), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
        .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
        .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .busy(busy)
    );

    mac_operand_sequencer #(.ACC_W(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .start(start2), .len(len2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_m(in_m2), .in_q(in_q2),
        .mul_m(mul_m2), .mul_q(mul_q2), .mul_p(mul_p2),
        .acc_out(acc_out2), .out_valid(out_valid2), .out_ready(out_ready2),
        .ovf(ovf2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one pair in LOAD, then spend the MAC cycle with different data offered.
    task automatic feed_pair(input logic [3:0] m, input logic [3:0] q);
        check("in_ready_load", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_m = m;
        in_q = q;
        tick();
        check("mul_m_loaded", 32'(mul_m), 32'(m));
        check("mul_q_loaded", 32'(mul_q), 32'(q));
        check("in_ready_mac", 32'(in_ready), 32'd0);
        in_m = m ^ 4'hF;
        in_q = q ^ 4'hF;
        tick();
        exp_acc += int'(m) * int'(q);
        check("mul_m_hold", 32'(mul_m), 32'(m));
        check("acc_running", 32'(acc_out), 32'(exp_acc));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; len = '0; in_valid = 1'b0; in_m = '0; in_q = '0; out_ready = 1'b0;
        start2 = 1'b0; len2 = '0; in_valid2 = 1'b0; in_m2 = '0; in_q2 = '0; out_ready2 = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); len = 4'($urandom); in_valid = 1'($urandom);
            in_m = 4'($urandom); in_q = 4'($urandom); out_ready = 1'($urandom);
            tick();
        end
        check("rst_mul_m", 32'(mul_m), 32'd0);
        check("rst_mul_q", 32'(mul_q), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        start = 1'b0; len = '0; in_valid = 1'b0; in_m = '0; in_q = '0; out_ready = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Basic burst: len 3, result 15 + 225 + 0 = 240 at cycle 7
        start = 1'b1; len = 4'd3; exp_acc = 0;
        tick();
        start = 1'b0;
        check("b_busy", 32'(busy), 32'd1);
        feed_pair(4'd3, 4'd5);
        feed_pair(4'd15, 4'd15);
        check("b_no_early_valid", 32'(out_valid), 32'd0);
        feed_pair(4'd0, 4'd9);
        in_valid = 1'b0;
        check("b_out_valid", 32'(out_valid), 32'd1);
        check("b_acc", 32'(acc_out), 32'h0F0);
        check("b_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b_idle", 32'(busy), 32'd0);
        check("b_valid_drop", 32'(out_valid), 32'd0);

        // Zero length burst
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        check("z_out_valid", 32'(out_valid), 32'd1);
        check("z_acc", 32'(acc_out), 32'd0);
        check("z_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("z_idle", 32'(busy), 32'd0);

        // Input stall then output backpressure: 16 + 2 = 18
        start = 1'b1; len = 4'd2; exp_acc = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s_in_ready", 32'(in_ready), 32'd1);
            check("s_mul_m", 32'(mul_m), 32'd0);
            check("s_mul_q", 32'(mul_q), 32'd9);
        end
        feed_pair(4'd4, 4'd4);
        feed_pair(4'd1, 4'd2);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_acc", 32'(acc_out), 32'd18);
            tick();
        end
        check("bp_out_valid_end", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", 32'(busy), 32'd0);

        // Maximum burst on the default width
        start = 1'b1; len = 4'd15; exp_acc = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) feed_pair(4'd15, 4'd15);
        in_valid = 1'b0;
        check("max_out_valid", 32'(out_valid), 32'd1);
        check("max_acc", 32'(acc_out), 32'hD2F);
        check("max_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Narrow accumulator: 225 + 225 = 450 wraps to 194 with carry
        start2 = 1'b1; len2 = 4'd2;
        tick();
        start2 = 1'b0; in_valid2 = 1'b1; in_m2 = 4'd15; in_q2 = 4'd15;
        tick(); tick();
        check("n8_mid_ovf", 32'(ovf2), 32'd0);
        check("n8_mid_acc", 32'(acc_out2), 32'd225);
        tick(); tick();
        in_valid2 = 1'b0;
        check("n8_out_valid", 32'(out_valid2), 32'd1);
        check("n8_acc", 32'(acc_out2), 32'hC2);
        check("n8_ovf", 32'(ovf2), 32'd1);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        check("n8_idle", 32'(busy2), 32'd0);

        // Reset after 2 of 4 pairs abandons the burst
        start = 1'b1; len = 4'd4; exp_acc = 0;
        tick();
        start = 1'b0;
        feed_pair(4'd1, 4'd1);
        feed_pair(4'd1, 4'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_acc", 32'(acc_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_valid", 32'(out_valid), 32'd0);
        end

        // New burst of one pair, start pulsed during MAC is ignored
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_m = 4'd2; in_q = 4'd3;
        tick();
        in_valid = 1'b0;
        start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        check("n_out_valid", 32'(out_valid), 32'd1);
        check("n_acc", 32'(acc_out), 32'd6);
        tick();
        check("n_done_hold", 32'(out_valid), 32'd1);
        check("n_acc_hold", 32'(acc_out), 32'd6);

        // Handoff with start high in DONE: start not honoured
        start = 1'b1; len = 4'd3; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("hs_idle", 32'(busy), 32'd0);
        tick();
        check("hs_still_idle", 32'(busy), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
